sm_iter_arith: RTL

- Parametrised multi-cycle arithmetic unit for the schoolMIPS core.
- Performs unsigned multiply, unsigned divide and integer square root iteratively, replacing the single-cycle combinational square root in the ALU.
- Results are delivered into HI/LO-style result registers.
- Handshake is start/busy/done. The CPU control stalls the PC while busy=1 and writes back hi/lo on done.

---
 rtl/sm_iter_arith.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/sm_iter_arith.sv
// Iterative MULTU / DIVU / SQRT unit for schoolMIPS with start/busy/done handshake.
// Results land in HI/LO registers; intermediate state lives only in the working registers.
module sm_iter_arith #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       oper,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic             kill,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             divZero
);

   localparam int HW = WIDTH / 2;
   localparam int RW = HW + 2;   // signed sqrt remainder width
   localparam logic [1:0] OP_MUL  = 2'b00;
   localparam logic [1:0] OP_DIV  = 2'b01;
   localparam logic [1:0] OP_SQRT = 2'b10;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       opReg;
   logic             zeroDiv;
   logic [WIDTH-1:0] accHi, accLo, opB;
   logic [RW-1:0]    sqRem;
   logic [HW-1:0]    sqRoot;

   logic [WIDTH:0]   mulSum, divShift, divDiff;
   logic             divGe;
   logic [RW-1:0]    sqShift, sqNextRem, sqFinal;
   logic [HW-1:0]    sqNextRoot;
   logic [WIDTH-1:0] stepHi, stepLo, resHi, resLo;
   logic             resDz;
   logic [CNT_W-1:0] loadCnt;

   assign busy = (state == RUN);

   always_comb begin
      mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : '0);
      divShift = {accHi, accLo[WIDTH-1]};
      divDiff  = divShift - {1'b0, opB};
      divGe    = ~divDiff[WIDTH];

      // Non-restoring root step: sign of the running remainder picks add or subtract.
      sqShift = {sqRem[RW-3:0], accLo[WIDTH-1 -: 2]};
      if (sqRem[RW-1])
         sqNextRem = sqShift + {sqRoot, 2'b11};
      else
         sqNextRem = sqShift - {sqRoot, 2'b01};
      sqNextRoot = {sqRoot[HW-2:0], ~sqNextRem[RW-1]};
      sqFinal    = sqNextRem[RW-1] ? sqNextRem + {1'b0, sqNextRoot, 1'b1} : sqNextRem;

      stepHi = accHi;
      stepLo = accLo;
      case (opReg)
         OP_MUL: begin
            stepHi = mulSum[WIDTH:1];
            stepLo = {mulSum[0], accLo[WIDTH-1:1]};
         end
         OP_DIV: begin
            stepHi = divGe ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
            stepLo = {accLo[WIDTH-2:0], divGe};
         end
         OP_SQRT: stepLo = {accLo[WIDTH-3:0], 2'b00};
         default: ;
      endcase

      resHi = '0;
      resLo = '0;
      resDz = 1'b0;
      case (opReg)
         OP_MUL: begin
            resHi = stepHi;
            resLo = stepLo;
         end
         OP_DIV: begin
            if (zeroDiv) begin
               resHi = accLo;
               resLo = '1;
               resDz = 1'b1;
            end else begin
               resHi = stepHi;
               resLo = stepLo;
            end
         end
         OP_SQRT: begin
            resHi = WIDTH'(sqFinal);
            resLo = WIDTH'(sqNextRoot);
         end
         default: ;
      endcase

      case (oper)
         OP_MUL:  loadCnt = CNT_W'(WIDTH);
         OP_DIV:  loadCnt = (srcB != '0) ? CNT_W'(WIDTH) : CNT_W'(1);
         OP_SQRT: loadCnt = CNT_W'(HW);
         default: loadCnt = CNT_W'(1);
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         done    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         divZero <= 1'b0;
         cnt     <= '0;
         opReg   <= '0;
         zeroDiv <= 1'b0;
         accHi   <= '0;
         accLo   <= '0;
         opB     <= '0;
         sqRem   <= '0;
         sqRoot  <= '0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start && !kill) begin
               state   <= RUN;
               opReg   <= oper;
               cnt     <= loadCnt;
               zeroDiv <= (oper == OP_DIV) && (srcB == '0);
               accHi   <= '0;
               sqRem   <= '0;
               sqRoot  <= '0;
               // Multiplier bits are consumed from accLo, so MULTU swaps the operands.
               if (oper == OP_MUL) begin
                  accLo <= srcB;
                  opB   <= srcA;
               end else begin
                  accLo <= srcA;
                  opB   <= srcB;
               end
            end
         end else if (kill) begin
            state <= IDLE;
            cnt   <= '0;
         end else begin
            cnt    <= cnt - 1'b1;
            accHi  <= stepHi;
            accLo  <= stepLo;
            sqRem  <= sqNextRem;
            sqRoot <= sqNextRoot;
            if (cnt == CNT_W'(1)) begin
               state   <= IDLE;
               done    <= 1'b1;
               hi      <= resHi;
               lo      <= resLo;
               divZero <= resDz;
            end
         end
      end
   end

endmodule
